imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface. The datapath only ever reads the IM.
//  This block receives a byte stream over a valid/ready handshake and assembles 32-bit
//  little-endian words. It writes them into the IM write port and holds the core
//  (cpu_hold) until a complete image has been loaded.
// PARAMETERS
//  ADDR_W     5      IM word-address width (depth = 2**ADDR_W words, matches pc[6:2])
//  SYNC_BYTE  8'hA5  frame start marker
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  byte_in      in   8       stream data byte
//  byte_valid   in   1       byte_in valid
//  byte_ready   out  1       loader can accept a byte; transfer = byte_valid & byte_ready at edge
//  im_we        out  1       IM write enable, exactly one cycle per word
//  im_waddr     out  ADDR_W  IM word address
//  im_wdata     out  32      IM write data
//  cpu_hold     out  1       1 = datapath PC held in reset
//  done         out  1       image loaded OK
//  error        out  1       frame error (sticky until next SYNC_BYTE or rst)
//  words_loaded out  ADDR_W+1  words written in current frame
// BEHAVIOUR
//  Reset values: state=IDLE, cpu_hold=1, done=0, error=0, im_we=0, im_waddr=0,
//   im_wdata=0, words_loaded=0. byte_ready=0 while rst=1. Reset mid-frame aborts the
//   frame; words already written stay in the IM.
//  Outputs are registered; byte_ready is decoded from state: 0 in WRITE, 1 elsewhere.
//  FSM:
//   IDLE : non-SYNC bytes discarded; SYNC_BYTE -> LEN.
//   LEN  : byte N = word count. N==0 or N>2**ADDR_W -> ERROR.
//          Otherwise latch N, clear word idx/byte idx/words_loaded -> DATA.
//   DATA : bytes packed LSB first (byte0 -> [7:0] ... byte3 -> [31:24]).
//          Accepting byte3 -> WRITE.
//   WRITE: one cycle; im_we=1, im_waddr=word idx, im_wdata=assembled word;
//          words_loaded+1. idx+1==N -> CHK if CHECKSUM_EN, else DONE; otherwise -> DATA.
//   DONE : done=1, cpu_hold=0. SYNC_BYTE -> LEN with done=0, cpu_hold=1.
//          Other bytes are ignored.
//   ERROR: error=1, cpu_hold=1. SYNC_BYTE -> LEN with error=0. Other bytes are ignored.
//  Latency: byte3 of a word is accepted at edge k; im_we is high from k to k+1, and
//   the IM captures the word at edge k+1. Min 5 cycles per word; no bubble when
//   byte_valid is held.
//  Gaps: byte_valid low at any point stalls the FSM indefinitely without state change.
//  N==2**ADDR_W fills the whole IM; the word idx never wraps within a frame.
//  cpu_hold deasserts in the same cycle done asserts; the PC restarts from 0.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//   - After the last WRITE, state CHK accepts one byte.
//   - The byte must equal the XOR of all 4*N data bytes. Match -> DONE; mismatch -> ERROR.
//   - Words stay written on a mismatch, but cpu_hold stays 1.
//  Not defined: no CHK state; the last WRITE goes directly to DONE. There is no checksum logic.
// TESTING
//  1 rst, SYNC, N=1, bytes 13 05 00 00 -> one im_we pulse, waddr=0, wdata=32'h00000513;
//    done=1, cpu_hold=0.
//  2 Stray 00 FF, then SYNC, N=2, 8 bytes -> strays ignored; writes at waddr 0,1;
//    words_loaded=2.
//  3 N=0 and N=33 (ADDR_W=5) -> error=1, no im_we. A following SYNC clears error.
//  4 byte_valid toggled 1/0 every cycle through a 2-word frame -> same writes as
//    with continuous valid; byte_ready=0 only in WRITE.
//  5 rst asserted after 2 bytes of word 1 -> all outputs at reset values next cycle;
//    a new frame loads correctly.
//  6 (CHECKSUM_EN) N=1, data 01 02 04 08, chk 0F -> done. Same data with chk 00 -> error=1,
//    cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port between the image loader and its surroundings.
// master = the loader (consumes bytes, drives the IM write port); slave = the stream source / IM side.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output im_we,
        output im_waddr,
        output im_wdata
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  im_we,
        input  im_waddr,
        input  im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a byte stream into little-endian words, writes them to the IM and holds the core until loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int             MAX_WORDS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ERROR,
        CHK
`else
        ERROR
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic accept;

    assign bus.byte_ready = !rst && (state_q != WRITE);
    assign accept         = bus.byte_valid && bus.byte_ready;

    assign bus.im_we      = im_we_q;
    assign bus.im_waddr   = im_waddr_q;
    assign bus.im_wdata   = im_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = words_loaded_q;

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        idx_d          = idx_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        im_we_d        = 1'b0;
        im_waddr_d     = im_waddr_q;
        im_wdata_d     = im_wdata_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d          = chk_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept && bus.byte_in == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                if (accept) begin
                    if (bus.byte_in == 8'd0 || int'(bus.byte_in) > MAX_WORDS) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end else begin
                        state_d        = DATA;
                        n_d            = (ADDR_W + 1)'(bus.byte_in);
                        idx_d          = '0;
                        byte_idx_d     = '0;
                        words_loaded_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_d          = '0;
`endif
                    end
                end
            end
            // Bytes 0..2 are parked in word_q; byte 3 completes the word straight into the write register.
            DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ bus.byte_in;
`endif
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = bus.byte_in;
                        2'd1: word_d[15:8]  = bus.byte_in;
                        2'd2: word_d[23:16] = bus.byte_in;
                        default: begin
                            state_d        = WRITE;
                            im_we_d        = 1'b1;
                            im_waddr_d     = idx_q[ADDR_W-1:0];
                            im_wdata_d     = {bus.byte_in, word_q};
                            words_loaded_d = words_loaded_q + ONE;
                        end
                    endcase
                end
            end
            WRITE: begin
                idx_d = idx_q + ONE;
                if (idx_q + ONE == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d    = CHK;
`else
                    state_d    = DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (bus.byte_in == chk_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                if (accept && bus.byte_in == SYNC_BYTE) begin
                    state_d    = LEN;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            ERROR: begin
                if (accept && bus.byte_in == SYNC_BYTE) begin
                    state_d = LEN;
                    error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            n_q            <= '0;
            idx_q          <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            im_we_q        <= 1'b0;
            im_waddr_q     <= '0;
            im_wdata_q     <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            idx_q          <= idx_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            im_we_q        <= im_we_d;
            im_waddr_q     <= im_waddr_d;
            im_wdata_q     <= im_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q          <= chk_d;
`endif
        end
    end

endmodule
